// File: rtl/dmem_router_pkg.sv
// Shared widths, bus codes, FSM states, request payload and byte-lane helpers
// for the data-memory router and its sub-blocks.
package dmem_router_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned MEM_COUNT_W = 2;
  localparam int unsigned MEM_CODE_W  = 2;

  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 2'd0;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd1;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd2;
  localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd3;

  localparam logic [MEM_CODE_W-1:0] MEM_CODE_READ          = 2'd0;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_WRITE         = 2'd1;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_OUT_OF_BOUNDS = 2'd2;
  localparam logic [MEM_CODE_W-1:0] MEM_CODE_MISALIGNED    = 2'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]      addr;
    logic [WORD_W-1:0]      wr_data;
    logic                   wr_en;
    logic [MEM_COUNT_W-1:0] count;
  } req_t;

  function automatic logic [WORD_W-1:0] lane_mask(input logic [MEM_COUNT_W-1:0] count);
    case (count)
      MEM_COUNT_BYTE: return WORD_W'(32'h0000_00FF);
      MEM_COUNT_HALF: return WORD_W'(32'h0000_FFFF);
      MEM_COUNT_WORD: return '1;
      default:        return '0;
    endcase
  endfunction

  // Right-aligned, zero-extended lane at byte offset off.
  function automatic logic [WORD_W-1:0] lane_extract(input logic [WORD_W-1:0] word,
                                                     input logic [1:0] off,
                                                     input logic [MEM_COUNT_W-1:0] count);
    return (word >> {off, 3'b000}) & lane_mask(count);
  endfunction

  function automatic logic [WORD_W-1:0] lane_merge(input logic [WORD_W-1:0] old,
                                                   input logic [WORD_W-1:0] data,
                                                   input logic [1:0] off,
                                                   input logic [MEM_COUNT_W-1:0] count);
    logic [WORD_W-1:0] m;
    m = lane_mask(count) << {off, 3'b000};
    return (old & ~m) | ((data << {off, 3'b000}) & m);
  endfunction

endpackage

// File: rtl/memory_interface.sv
// Word-organised RAM with sub-word lanes: combinational read, write committed
// on the clock edge whenever count is not NONE.
module memory_interface
  import dmem_router_pkg::*;
#(
  parameter int unsigned WORD_COUNT = 1024
) (
  input  logic                   clk,
  input  logic [MEM_COUNT_W-1:0] count,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [WORD_W-1:0]      wr_data,
  input  logic                   wr_en,
  output logic [WORD_W-1:0]      rd_data_c,
  output logic [MEM_CODE_W-1:0]  code_c
);

  localparam int unsigned IDX_W = (WORD_COUNT > 1) ? $clog2(WORD_COUNT) : 1;
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(4 * WORD_COUNT);

  logic [WORD_W-1:0] mem [WORD_COUNT];
  logic [IDX_W-1:0]  idx;
  logic              in_range;

  assign idx      = addr[IDX_W+1:2];
  assign in_range = addr < LIMIT;

  always_ff @(posedge clk) begin
    if (count != MEM_COUNT_NONE && wr_en && in_range)
      mem[idx] <= lane_merge(mem[idx], wr_data, addr[1:0], count);
  end

  always_comb begin
    rd_data_c = '0;
    code_c    = MEM_CODE_READ;
    if (count != MEM_COUNT_NONE) begin
      if (!in_range)  code_c = MEM_CODE_OUT_OF_BOUNDS;
      else if (wr_en) code_c = MEM_CODE_WRITE;
      else            rd_data_c = lane_extract(mem[idx], addr[1:0], count);
    end
  end

endmodule

// File: rtl/periph_regs.sv
// Peripheral window: writable output registers followed by read-only input
// registers, with lane merge/extract and one-cycle write strobes.
module periph_regs
  import dmem_router_pkg::*;
#(
  parameter int unsigned OUT_COUNT = 4,
  parameter int unsigned IN_COUNT  = 2,
  parameter int unsigned IDX_W     = 3
) (
  input  logic                          clk,
  input  logic                          areset,
  input  logic                          wr,
  input  logic [IDX_W-1:0]              idx,
  input  logic [1:0]                    off,
  input  logic [MEM_COUNT_W-1:0]        count,
  input  logic [WORD_W-1:0]             wr_data,
  input  logic [IN_COUNT*WORD_W-1:0]    periph_in,
  output logic [WORD_W-1:0]             rd_data_c,
  output logic [OUT_COUNT*WORD_W-1:0]   periph_out,
  output logic [OUT_COUNT-1:0]          wr_stb
);

  logic [WORD_W-1:0] regs [OUT_COUNT];
  logic [WORD_W-1:0] sel_word;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int k = 0; k < OUT_COUNT; k++) regs[k] <= '0;
      wr_stb <= '0;
    end else begin
      wr_stb <= '0;
      for (int k = 0; k < OUT_COUNT; k++) begin
        if (wr && idx == IDX_W'(k)) begin
          regs[k]   <= lane_merge(regs[k], wr_data, off, count);
          wr_stb[k] <= 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < OUT_COUNT; g++) begin : g_out
    assign periph_out[g*WORD_W +: WORD_W] = regs[g];
  end

  // Input registers sit directly after the output registers in the window.
  always_comb begin
    sel_word = '0;
    for (int k = 0; k < OUT_COUNT; k++)
      if (idx == IDX_W'(k)) sel_word = regs[k];
    for (int j = 0; j < IN_COUNT; j++)
      if (idx == IDX_W'(OUT_COUNT + j)) sel_word = periph_in[j*WORD_W +: WORD_W];
    rd_data_c = lane_extract(sel_word, off, count);
  end

endmodule

// File: rtl/dmem_router.sv
// Load/store bus router: valid/ready request, two-cycle registered response,
// alignment check and decode between RAM and the peripheral register window.
module dmem_router
  import dmem_router_pkg::*;
#(
  parameter int unsigned       WORD_COUNT       = 1024,
  parameter logic [ADDR_W-1:0] PERIPH_BASE      = 32'h8000_0000,
  parameter int unsigned       PERIPH_OUT_COUNT = 4,
  parameter int unsigned       PERIPH_IN_COUNT  = 2
) (
  input  logic                                 clk,
  input  logic                                 areset,
  input  logic                                 i_req_valid,
  output logic                                 o_req_ready,
  input  logic [ADDR_W-1:0]                    i_req_addr,
  input  logic [WORD_W-1:0]                    i_req_wr_data,
  input  logic                                 i_req_wr_en,
  input  logic [MEM_COUNT_W-1:0]               i_req_count,
  output logic                                 o_res_valid,
  output logic [WORD_W-1:0]                    o_res_rd_data,
  output logic [MEM_CODE_W-1:0]                o_res_code,
  output logic [PERIPH_OUT_COUNT*WORD_W-1:0]   o_periph_out,
  output logic [PERIPH_OUT_COUNT-1:0]          o_periph_wr_stb,
  input  logic [PERIPH_IN_COUNT*WORD_W-1:0]    i_periph_in
);

  localparam int unsigned       REG_COUNT = PERIPH_OUT_COUNT + PERIPH_IN_COUNT;
  localparam int unsigned       IDX_W     = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [ADDR_W-1:0] RAM_LIMIT = ADDR_W'(4 * WORD_COUNT);
  localparam logic [ADDR_W-1:0] WIN_SIZE  = ADDR_W'(4 * REG_COUNT);
  localparam logic [ADDR_W-1:0] OUT_SIZE  = ADDR_W'(4 * PERIPH_OUT_COUNT);
  localparam logic [ADDR_W:0]   WIN_END   = {1'b0, PERIPH_BASE} + (ADDR_W+1)'(4 * REG_COUNT);

  if (PERIPH_BASE[1:0] != 2'b00 || (WIN_END[ADDR_W] && WIN_END[ADDR_W-1:0] != '0) ||
      PERIPH_BASE < RAM_LIMIT) begin : g_bad_window
    $error("dmem_router: peripheral window misaligned, wraps the address space, or overlaps RAM");
  end

  state_t                 state, next_state;
  req_t                   req;
  logic                   ready_q, ready_d;
  logic                   res_valid_q, res_valid_d;
  logic [WORD_W-1:0]      res_data_q, res_data_d;
  logic [MEM_CODE_W-1:0]  res_code_q, res_code_d;
  logic                   accept, load_req;
  logic                   misaligned, in_ram, in_periph, is_out;
  logic [ADDR_W-1:0]      win_off;
  logic [IDX_W-1:0]       pidx;
  logic [MEM_COUNT_W-1:0] mem_count;
  logic [WORD_W-1:0]      mem_rd, periph_rd;
  logic [MEM_CODE_W-1:0]  mem_code;
  logic                   periph_wr;

  assign accept     = i_req_valid & ready_q;
  assign misaligned = (req.count == MEM_COUNT_HALF && req.addr[0]) ||
                      (req.count == MEM_COUNT_WORD && req.addr[1:0] != 2'b00);
  assign in_ram     = req.addr < RAM_LIMIT;
  assign win_off    = req.addr - PERIPH_BASE;
  assign in_periph  = (req.addr >= PERIPH_BASE) && (win_off < WIN_SIZE);
  assign is_out     = win_off < OUT_SIZE;
  assign pidx       = IDX_W'(win_off >> 2);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state       <= ST_IDLE;
      req         <= '0;
      ready_q     <= 1'b1;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_code_q  <= '0;
    end else begin
      state       <= next_state;
      ready_q     <= ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_code_q  <= res_code_d;
      if (load_req)
        req <= '{addr: i_req_addr, wr_data: i_req_wr_data, wr_en: i_req_wr_en, count: i_req_count};
    end
  end

  // Next state, decode of the latched request, and response capture.
  always_comb begin
    next_state  = ST_IDLE;
    load_req    = 1'b0;
    mem_count   = MEM_COUNT_NONE;
    periph_wr   = 1'b0;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_code_d  = res_code_q;
    case (state)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          load_req = 1'b1;
          if (i_req_count != MEM_COUNT_NONE) next_state = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        next_state  = ST_RESP;
        res_valid_d = 1'b1;
        res_data_d  = '0;
        res_code_d  = MEM_CODE_OUT_OF_BOUNDS;
        if (misaligned) begin
          res_code_d = MEM_CODE_MISALIGNED;
        end else if (in_ram) begin
          mem_count  = req.count;
          res_data_d = mem_rd;
          res_code_d = mem_code;
        end else if (in_periph) begin
          if (!req.wr_en) begin
            res_data_d = periph_rd;
            res_code_d = MEM_CODE_READ;
          end else if (is_out) begin
            periph_wr  = 1'b1;
            res_code_d = MEM_CODE_WRITE;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
    ready_d = (next_state != ST_ACCESS);
  end

  memory_interface #(.WORD_COUNT(WORD_COUNT)) u_mem (
    .clk       (clk),
    .count     (mem_count),
    .addr      (req.addr),
    .wr_data   (req.wr_data),
    .wr_en     (req.wr_en),
    .rd_data_c (mem_rd),
    .code_c    (mem_code)
  );

  periph_regs #(
    .OUT_COUNT (PERIPH_OUT_COUNT),
    .IN_COUNT  (PERIPH_IN_COUNT),
    .IDX_W     (IDX_W)
  ) u_periph (
    .clk        (clk),
    .areset     (areset),
    .wr         (periph_wr),
    .idx        (pidx),
    .off        (req.addr[1:0]),
    .count      (req.count),
    .wr_data    (req.wr_data),
    .periph_in  (i_periph_in),
    .rd_data_c  (periph_rd),
    .periph_out (o_periph_out),
    .wr_stb     (o_periph_wr_stb)
  );

  assign o_req_ready   = ready_q;
  assign o_res_valid   = res_valid_q;
  assign o_res_rd_data = res_data_q;
  assign o_res_code    = res_code_q;

endmodule

// File: tb/tb_dmem_router.sv
// Scoreboard bench for dmem_router: directed requests push expected responses,
// a negedge monitor pops and compares each response strobe.
module tb_dmem_router;
  import dmem_router_pkg::*;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [127:0] P0 = '0;
  localparam logic [127:0] P1 = {32'h0, 32'h0, 32'h0000_AB00, 32'h0};
  localparam logic [127:0] P2 = {32'h0, 32'h0, 32'h0000_AB00, 32'hCAFE_F00D};

  logic         clk = 1'b0;
  logic         areset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [31:0]  req_addr = '0;
  logic [31:0]  req_wr_data = '0;
  logic         req_wr_en = 1'b0;
  logic [1:0]   req_count = '0;
  logic         res_valid;
  logic [31:0]  res_rd_data;
  logic [1:0]   res_code;
  logic [127:0] periph_out;
  logic [3:0]   periph_stb;
  logic [63:0]  periph_in = '0;

  typedef struct {
    string        name;
    logic [31:0]  data;
    bit           chk_data;
    logic [1:0]   code;
    int           cyc;
    bit           chk_per;
    logic [127:0] per;
    logic [3:0]   stb;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  logic rlog[$];
  int   checks = 0, errors = 0, cycle = 0;
  int   stb_cycles = 0, mem_bad = 0;
  bit   watch_mem = 1'b0, b2b_on = 1'b0;

  always #5 clk = ~clk;

  dmem_router dut (
    .clk             (clk),
    .areset          (areset),
    .i_req_valid     (req_valid),
    .o_req_ready     (req_ready),
    .i_req_addr      (req_addr),
    .i_req_wr_data   (req_wr_data),
    .i_req_wr_en     (req_wr_en),
    .i_req_count     (req_count),
    .o_res_valid     (res_valid),
    .o_res_rd_data   (res_rd_data),
    .o_res_code      (res_code),
    .o_periph_out    (periph_out),
    .o_periph_wr_stb (periph_stb),
    .i_periph_in     (periph_in)
  );

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Response monitor and side-channel observers.
  always @(negedge clk) begin
    if (!areset && periph_stb != 4'b0) stb_cycles++;
    if (watch_mem && dut.mem_count != MEM_COUNT_NONE) mem_bad++;
    if (!areset && res_valid) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_response: got code %0d data %h expected no response", res_code, res_rd_data);
      end else begin
        mon_e = q.pop_front();
        check({mon_e.name, "_code"}, 128'(res_code), 128'(mon_e.code));
        check({mon_e.name, "_latency"}, 128'(cycle), 128'(mon_e.cyc));
        if (mon_e.chk_data) check({mon_e.name, "_data"}, 128'(res_rd_data), 128'(mon_e.data));
        if (mon_e.chk_per) begin
          check({mon_e.name, "_periph_out"}, periph_out, mon_e.per);
          check({mon_e.name, "_stb"}, 128'(periph_stb), 128'(mon_e.stb));
        end
      end
    end
  end

  task automatic issue(input string name, input logic [31:0] addr, input logic [31:0] data,
                       input bit wr, input logic [1:0] cnt,
                       input logic [31:0] exp_data, input bit chk_data, input logic [1:0] exp_code,
                       input bit chk_per, input logic [127:0] per, input logic [3:0] stb,
                       input bit hold);
    bit   got;
    exp_t e;
    req_valid   = 1'b1;
    req_addr    = addr;
    req_wr_data = data;
    req_wr_en   = wr;
    req_count   = cnt;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      if (b2b_on) rlog.push_back(req_ready);
      if (req_ready) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: got ready 0 for 20 cycles expected ready 1", name);
    end else if (cnt != MEM_COUNT_NONE) begin
      e = '{name: name, data: exp_data, chk_data: chk_data, code: exp_code, cyc: cycle + 2,
            chk_per: chk_per, per: per, stb: stb};
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int n = 0; n < 10 && !done; n++) begin
      @(negedge clk);
      if (q.size() == 0) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 128'(req_ready), 128'(1));
    check("rst_res_valid", 128'(res_valid), 128'(0));
    check("rst_rd_data", 128'(res_rd_data), 128'(0));
    check("rst_code", 128'(res_code), 128'(0));
    check("rst_periph_out", periph_out, P0);
    check("rst_stb", 128'(periph_stb), 128'(0));
    @(posedge clk);
    #1 areset = 1'b0;

    issue("ram_st_word", 32'h10, 32'hDEAD_BEEF, 1, MEM_COUNT_WORD, 0, 0, MEM_CODE_WRITE, 0, P0, 0, 0); drain();
    issue("ram_ld_word", 32'h10, 0, 0, MEM_COUNT_WORD, 32'hDEAD_BEEF, 1, MEM_CODE_READ, 0, P0, 0, 0); drain();
    issue("ram_ld_half", 32'h12, 0, 0, MEM_COUNT_HALF, 32'h0000_DEAD, 1, MEM_CODE_READ, 0, P0, 0, 0); drain();
    issue("per_st_byte", BASE + 32'h5, 32'hAB, 1, MEM_COUNT_BYTE, 0, 0, MEM_CODE_WRITE, 1, P1, 4'b0010, 0); drain();
    @(negedge clk);
    check("per_stb_clear", 128'(periph_stb), 128'(0));
    @(posedge clk);
    #1;
    issue("per_ld_byte", BASE + 32'h5, 0, 0, MEM_COUNT_BYTE, 32'hAB, 1, MEM_CODE_READ, 1, P1, 0, 0); drain();

    periph_in = {32'h9ABC_DEF0, 32'h1234_5678};
    issue("in_ld_half", BASE + 32'h12, 0, 0, MEM_COUNT_HALF, 32'h0000_1234, 1, MEM_CODE_READ, 0, P0, 0, 0); drain();
    issue("in_ld_byte", BASE + 32'h17, 0, 0, MEM_COUNT_BYTE, 32'h0000_009A, 1, MEM_CODE_READ, 0, P0, 0, 0); drain();
    issue("in_st_half", BASE + 32'h12, 32'hFFFF, 1, MEM_COUNT_HALF, 0, 1, MEM_CODE_OUT_OF_BOUNDS, 1, P1, 0, 0); drain();

    watch_mem = 1'b1;
    issue("mis_word", 32'h6, 0, 0, MEM_COUNT_WORD, 0, 1, MEM_CODE_MISALIGNED, 0, P0, 0, 0); drain();
    issue("mis_half", 32'h11, 0, 1, MEM_COUNT_HALF, 0, 1, MEM_CODE_MISALIGNED, 0, P0, 0, 0); drain();
    issue("oob_ram_end", 32'h1000, 0, 0, MEM_COUNT_WORD, 0, 1, MEM_CODE_OUT_OF_BOUNDS, 0, P0, 0, 0); drain();
    issue("oob_win_end", BASE + 32'h18, 0, 0, MEM_COUNT_WORD, 0, 1, MEM_CODE_OUT_OF_BOUNDS, 0, P0, 0, 0); drain();
    watch_mem = 1'b0;
    check("mem_count_none", 128'(mem_bad), 128'(0));

    issue("drop_none", 32'h10, 0, 0, MEM_COUNT_NONE, 0, 0, MEM_CODE_READ, 0, P0, 0, 0); drain();
    check("drop_ready", 128'(req_ready), 128'(1));

    b2b_on = 1'b1;
    issue("b2b_ram_st", 32'h20, 32'h1122_3344, 1, MEM_COUNT_WORD, 0, 0, MEM_CODE_WRITE, 0, P0, 0, 1);
    issue("b2b_per_st", BASE, 32'hCAFE_F00D, 1, MEM_COUNT_WORD, 0, 0, MEM_CODE_WRITE, 1, P2, 4'b0001, 1);
    issue("b2b_ram_ld", 32'h21, 0, 0, MEM_COUNT_BYTE, 32'h33, 1, MEM_CODE_READ, 0, P0, 0, 0);
    b2b_on = 1'b0;
    drain();
    check("b2b_ready_len", 128'(rlog.size()), 128'(5));
    if (rlog.size() == 5) begin
      check("b2b_ready_0", 128'(rlog[0]), 128'(1));
      check("b2b_ready_1", 128'(rlog[1]), 128'(0));
      check("b2b_ready_2", 128'(rlog[2]), 128'(1));
      check("b2b_ready_3", 128'(rlog[3]), 128'(0));
      check("b2b_ready_4", 128'(rlog[4]), 128'(1));
    end

    req_valid   = 1'b1;
    req_addr    = BASE + 32'h8;
    req_wr_data = 32'h55;
    req_wr_en   = 1'b1;
    req_count   = MEM_COUNT_WORD;
    @(negedge clk);
    check("rst_test_accept_ready", 128'(req_ready), 128'(1));
    @(posedge clk);
    #1;
    check("rst_test_in_access", 128'(req_ready), 128'(0));
    areset    = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 areset = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_test_periph_out", periph_out, P0);
    check("rst_test_stb", 128'(periph_stb), 128'(0));
    check("rst_test_ready", 128'(req_ready), 128'(1));
    check("rst_test_state", 128'(dut.state), 128'(ST_IDLE));

    check("queue_empty", 128'(q.size()), 128'(0));
    check("stb_pulse_cycles", 128'(stb_cycles), 128'(2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish before 100000");
    $fatal(1);
  end

endmodule
